fft_result_drain: RTL

//  Output-side reader for the FFT datapath: once the last butterfly stage reports done,

---
 rtl/fft_result_drain.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/fft_result_drain.sv
// fft_result_drain: output-side reader for the FFT datapath.
// After done_i, the block reads the N results of the final stage RAM in
// bit-reversed address order and streams them out in natural frequency order
// on a valid/ready port. Reads are credit-limited so that the return skid FIFO
// (depth RD_LAT+1) can absorb every read in flight when downstream stalls.
module fft_result_drain #(
  parameter int bit_width = 29,
  parameter int N         = 16,
  parameter int SIZE      = 4,
  parameter int RD_LAT    = 2,
  parameter int BITREV    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 done_i,
  output logic                 rd_en,
  output logic [SIZE-1:0]      rd_ptr,
  input  logic [bit_width-1:0] rd_re,
  input  logic [bit_width-1:0] rd_im,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [bit_width-1:0] out_re,
  output logic [bit_width-1:0] out_im,
  output logic [SIZE-1:0]      out_index,
  output logic                 out_last,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 overrun
);

  localparam int DEPTH = RD_LAT + 1;          // skid FIFO depth == read credits
  localparam int PW    = $clog2(DEPTH);       // FIFO pointer width (DEPTH >= 2)
  localparam int CW    = $clog2(DEPTH + 1);   // holds counts 0..DEPTH
  localparam int EW    = 2 * bit_width + SIZE;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  localparam logic [SIZE-1:0] LAST_IDX = SIZE'(N - 1);
  localparam logic [CW:0]     CREDITS  = (CW + 1)'(DEPTH);

  function automatic logic [SIZE-1:0] bit_reverse(input logic [SIZE-1:0] v);
    logic [SIZE-1:0] r;
    r = '0;
    for (int i = 0; i < SIZE; i++) r[i] = v[SIZE-1-i];
    return r;
  endfunction

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [1:0]      state;
  logic [SIZE-1:0] issue_idx;

  // Read-return shadow pipe: valid bit and natural index travel with each read.
  logic [RD_LAT-1:0] pipe_valid;
  logic [SIZE-1:0]   pipe_idx [RD_LAT];
  logic [CW-1:0]     inflight;

  // Skid FIFO.
  logic [EW-1:0]   fifo_mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr_q;
  logic [CW-1:0]   fifo_count;
  logic            fifo_empty;

  logic            ret_valid;
  logic [EW-1:0]   ret_entry;
  logic [EW-1:0]   head;
  logic [CW:0]     outstanding;
  logic            pop;
  logic            push;
  logic            fifo_pop;

  // Issue side: a read goes out only while a FIFO slot is guaranteed for it.
  assign outstanding = {1'b0, fifo_count} + {1'b0, inflight};
  assign rd_en       = (state == S_ISSUE) && (outstanding < CREDITS);
  assign rd_ptr      = (BITREV != 0) ? bit_reverse(issue_idx) : issue_idx;
  assign busy        = (state != S_IDLE);

  // Return side: the pipe exit lines up with the RAM data of the same read.
  assign ret_valid  = pipe_valid[RD_LAT-1];
  assign ret_entry  = {rd_re, rd_im, pipe_idx[RD_LAT-1]};
  assign fifo_empty = (fifo_count == '0);

  // An empty FIFO passes returning data straight through, so the first sample
  // is presented in the same cycle the RAM delivers it. A stalled bypass sample
  // is captured and re-presented unchanged from the FIFO head next cycle.
  assign out_valid = !fifo_empty || ret_valid;
  assign head      = fifo_empty ? ret_entry : fifo_mem[rd_ptr_q];
  assign out_re    = out_valid ? head[EW-1 -: bit_width]        : '0;
  assign out_im    = out_valid ? head[SIZE +: bit_width]        : '0;
  assign out_index = out_valid ? head[SIZE-1:0]                 : '0;
  assign out_last  = out_valid && (out_index == LAST_IDX);

  assign pop      = out_valid && out_ready;
  assign fifo_pop = pop && !fifo_empty;
  assign push     = ret_valid && !(fifo_empty && out_ready);

  // Frame sequencing: IDLE -> ISSUE on done_i, ISSUE -> FLUSH on the last read,
  // FLUSH -> IDLE on the out_last handshake.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      issue_idx <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (done_i) begin
            state     <= S_ISSUE;
            issue_idx <= '0;
          end
        end
        S_ISSUE: begin
          if (rd_en) begin
            if (issue_idx == LAST_IDX) state <= S_FLUSH;
            else                       issue_idx <= issue_idx + 1'b1;
          end
        end
        S_FLUSH: begin
          if (pop && out_last) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Shadow pipe and in-flight read counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_valid <= '0;
      inflight   <= '0;
      for (int k = 0; k < RD_LAT; k++) pipe_idx[k] <= '0;
    end else begin
      pipe_valid[0] <= rd_en;
      pipe_idx[0]   <= issue_idx;
      for (int k = 1; k < RD_LAT; k++) begin
        pipe_valid[k] <= pipe_valid[k-1];
        pipe_idx[k]   <= pipe_idx[k-1];
      end
      inflight <= inflight + CW'(rd_en) - CW'(ret_valid);
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr_q   <= '0;
      fifo_count <= '0;
    end else begin
      if (push)     wr_ptr   <= ptr_next(wr_ptr);
      if (fifo_pop) rd_ptr_q <= ptr_next(rd_ptr_q);
      fifo_count <= fifo_count + CW'(push) - CW'(fifo_pop);
    end
  end

  // FIFO storage write.
  // NOTE: storage is not reset; occupancy is, and nothing reads an empty slot.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= ret_entry;
  end

  // Status pulses: frame end one cycle after the last handshake, and a done_i
  // that arrives while a frame is running (that pulse is otherwise ignored).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_done <= (state == S_FLUSH) && pop && out_last;
      overrun    <= done_i && (state != S_IDLE);
    end
  end

  // The credit rule must make FIFO overflow impossible.
  fifo_overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !fifo_pop && (fifo_count == CW'(DEPTH))));

endmodule
